// File: rtl/rx_reply_arbiter.sv
// Two-requester arbiter that owns the RX buffer write path for one whole packet at a time.
// Optional idle-grant watchdog compiled in with `define RX_ARB_WATCHDOG_EN.
module rx_reply_arbiter #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
    input  logic        txclk,
    input  logic        reset_n,
    input  logic [1:0]  req,
    input  logic [1:0]  wr,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    input  logic [1:0]  done,
    input  logic        rx_WR_enabled,
    output logic [1:0]  grant,
    output logic [1:0]  wr_enabled,
    output logic        rx_WR,
    output logic [15:0] rx_databus,
    output logic        rx_WR_done,
    output logic        timeout_flag,
    output logic [7:0]  debug
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;
    localparam logic [1:0] GAP  = 2'd3;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic        last;
    logic        last_nxt;
    logic        own;
    logic        idx;
    logic        wr_own;
    logic        done_own;
    logic        wdog_fire;
    logic        release_pkt;
    logic [15:0] word_own;

    // Strobes from the requester that does not own the path are masked here, so they never reach state.
    assign own         = (state == OWN0) || (state == OWN1);
    assign idx         = (state == OWN1);
    assign wr_own      = own & wr[idx];
    assign done_own    = own & done[idx];
    assign word_own    = idx ? data1 : data0;
    assign release_pkt = done_own | wdog_fire;

    assign grant      = {state == OWN1, state == OWN0};
    assign wr_enabled = grant & {2{rx_WR_enabled}};
    assign debug      = {state, grant, last, timeout_flag, rx_WR, rx_WR_enabled};

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_nxt = state;
        last_nxt  = last;
        case (state)
            IDLE: begin
                case (req)
                    2'b01: begin
                        state_nxt = OWN0;
                        last_nxt  = 1'b0;
                    end
                    2'b10: begin
                        state_nxt = OWN1;
                        last_nxt  = 1'b1;
                    end
                    2'b11: begin
                        state_nxt = last ? OWN0 : OWN1;
                        last_nxt  = ~last;
                    end
                    default: ;
                endcase
            end
            OWN0, OWN1: if (release_pkt) state_nxt = GAP;
            GAP:        state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge txclk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last       <= 1'b1;
            rx_WR      <= 1'b0;
            rx_WR_done <= 1'b0;
            rx_databus <= 16'h0000;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state      <= state_nxt;
            last       <= last_nxt;
            rx_WR      <= wr_own;
            rx_WR_done <= release_pkt;
            if (wr_own) rx_databus <= word_own;
        end
    end

`ifdef RX_ARB_WATCHDOG_EN
    logic [15:0] wdog_cnt;
    logic        flag_q;

    // Fires on the TIMEOUT_CYCLES-th consecutive owned cycle without a word; done wins a tie.
    assign wdog_fire    = own & ~wr_own & ~done_own & (wdog_cnt == (TIMEOUT_CYCLES - 16'd1));
    assign timeout_flag = flag_q;

    always_ff @(posedge txclk or negedge reset_n) begin
        if (!reset_n) begin
            wdog_cnt <= 16'd0;
            flag_q   <= 1'b0;
        end else begin
            if (!own || wr_own) wdog_cnt <= 16'd0;
            else                wdog_cnt <= wdog_cnt + 16'd1;
            if (wdog_fire) flag_q <= 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign wdog_fire      = 1'b0;
    assign timeout_flag   = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

endmodule
